// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that streams bytes into a frame RAM write port with wrap and frame-done flag.
// Optional idle-timeout frame resync is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT    = 1085,
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_W          = 15,
  parameter int TIMEOUT_CLKS    = 62500000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Rx,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic              o_Frame_Done,
  output logic              o_Frame_Err,
  output logic              o_Busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_sync;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [ADDR_W-1:0] addr;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Synchroniser resets to the idle-high line level so reset release is not seen as a start bit.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= S_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      addr         <= '0;
      o_Wr_En      <= 1'b0;
      o_Wr_Addr    <= '0;
      o_Wr_Data    <= '0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Busy       <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      o_Wr_En      <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;

      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) begin
            state  <= S_START;
            o_Busy <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject short low glitches.
        S_START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              state <= S_DATA;
            end else begin
              state  <= S_IDLE;
              o_Busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              o_Wr_En   <= 1'b1;
              o_Wr_Data <= shift;
              o_Wr_Addr <= addr;
              state     <= S_IDLE;
              o_Busy    <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
              to_cnt    <= '0;
`endif
              if (addr == LAST_ADDR) begin
                o_Frame_Done <= 1'b1;
                addr         <= '0;
              end else begin
                addr <= addr + 1'b1;
              end
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // Wait out a held-low line so a break produces a single error.
        S_BREAK: begin
          if (rx_sync) begin
            state  <= S_IDLE;
            o_Busy <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          o_Busy <= 1'b0;
        end
      endcase

`ifdef UART_FRAME_TIMEOUT_EN
      // A long idle gap mid-frame means bytes were lost; restart the frame at address 0.
      if (state == S_IDLE && addr != '0) begin
        if (to_cnt == TO_LAST) begin
          addr   <= '0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
